// File: rtl/logic_op_arbiter_pkg.sv
// Shared types for the logic-op arbiter: opcode encoding and sequencer states.
// Package name logic_op_pkg is imported by the gate unit, the arbiter and the bench.
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_NAND  = 3'd2,
    OP_NOR   = 3'd3,
    OP_XOR   = 3'd4,
    OP_XNOR  = 3'd5,
    OP_NOT_A = 3'd6,
    OP_NOT_B = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_op_arbiter_if.sv
// Request/response bundle between client engines and the shared logic unit.
// Handshake: a beat transfers on a rising clk edge where valid and ready are both 1;
// valid never waits on ready, payload is held stable while valid is high and not yet accepted.
interface logic_op_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/logic_op_arbiter_gate_unit.sv
// Purely combinational W-bit bitwise logic unit; the single home of opcode decode.
module logic_gate_unit
  import logic_op_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      OP_NOT_A: y = ~a;
      OP_NOT_B: y = ~b;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Arbitrates NREQ requesters onto one logic_gate_unit through an IDLE/EXEC/RESP sequencer.
// Build option LOGIC_ARB_FIXED_PRIO_EN: lowest index always wins (no round-robin pointer).
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_op_arbiter_if.slave    bus,
  output state_t               dbg_state
);

  localparam int IDW = $clog2(NREQ);

  state_t         state;
  state_t         state_nxt;
  logic           grant_any;
  logic [IDW-1:0] winner;
  logic           accept;

  logic [W-1:0]   lat_a;
  logic [W-1:0]   lat_b;
  op_t            lat_op;
  logic [IDW-1:0] lat_id;
  logic [W-1:0]   gate_y;
  logic [W-1:0]   rsp_data_q;
  logic [IDW-1:0] rsp_id_q;

`ifdef LOGIC_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest valid index is the last (and final) assignment.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        grant_any = 1'b1;
        winner    = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0] ptr;

  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        grant_any = 1'b1;
        winner    = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Pointer moves only on an actual transfer, so a requester that gives up is never skipped over.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
    end
  end
`endif

  assign accept = rst_n && (state == IDLE) && grant_any;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[winner] = 1'b1;
    end
    bus.rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= OP_AND;
      lat_id     <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      if (accept) begin
        lat_a  <= bus.req_a[int'(winner) * W +: W];
        lat_b  <= bus.req_b[int'(winner) * W +: W];
        lat_op <= op_t'(bus.req_op[int'(winner) * OP_W +: OP_W]);
        lat_id <= winner;
      end
      if (state == EXEC) begin
        rsp_data_q <= gate_y;
        rsp_id_q   <= lat_id;
      end
    end
  end

  logic_gate_unit #(.W(W)) u_gate (
    .a  (lat_a),
    .b  (lat_b),
    .op (lat_op),
    .y  (gate_y)
  );

  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_id   = rsp_id_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_logic_op_arbiter;
  import logic_op_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = $clog2(NREQ);

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;

  logic_op_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  logic_op_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_mis = 0;

  logic [IDW+W-1:0] exp_q[$];
  int               exp_grant_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic rsp_valid_q = 1'b0;
  int   last_grant_cyc = 0;
  int   gid;
  logic [IDW+W-1:0] exp_rsp;

  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_valid_q = 1'b0;
    end else begin
      if (|(bus.req_valid & bus.req_ready)) begin
        gid = 0;
        for (int k = 0; k < NREQ; k++) if (bus.req_ready[k]) gid = k;
        check("grant_onehot", 32'($onehot(bus.req_ready)), 32'd1);
        if (exp_grant_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_grant: got id %0d, expected no grant", gid);
        end else begin
          check("grant_id", gid, exp_grant_q.pop_front());
        end
        last_grant_cyc = cyc;
      end
      if (bus.rsp_valid && !rsp_valid_q)
        check("rsp_latency", cyc - last_grant_cyc, 32'd2);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_rsp: got id %0d data %0h, expected no response",
                   bus.rsp_id, bus.rsp_data);
        end else begin
          exp_rsp = exp_q.pop_front();
          check("rsp_id", bus.rsp_id, exp_rsp[IDW+W-1:W]);
          check("rsp_data", bus.rsp_data, exp_rsp[W-1:0]);
        end
      end
      rsp_valid_q = bus.rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
    bus.req_a[id*W +: W]  = a;
    bus.req_b[id*W +: W]  = b;
    bus.req_op[id*3 +: 3] = op;
    bus.req_valid[id]     = 1'b1;
  endtask

  task automatic clr_req(input int id);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic expect_op(input int id, input logic [W-1:0] data);
    exp_grant_q.push_back(id);
    exp_q.push_back({IDW'(id), data});
  endtask

  // Returns 1 time unit after the edge that accepted the last expected grant.
  task automatic wait_grants();
    int n = 0;
    while (exp_grant_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_grant_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL grant_timeout: %0d grants outstanding, expected 0", exp_grant_q.size());
      exp_grant_q.delete();
    end
    #1;
  endtask

  task automatic wait_rsps();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  logic [W-1:0] sweep_exp [8];

  initial begin
    sweep_exp = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hF0};
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // Reset: no ready even with every requester valid, outputs cleared
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 32'd0);
      check("rst_rsp_valid", bus.rsp_valid, 32'd0);
      check("rst_rsp_data", bus.rsp_data, 32'd0);
      check("rst_rsp_id", bus.rsp_id, 32'd0);
      check("rst_state", dbg_state, IDLE);
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single XOR on requester 0
    set_req(0, 8'hF0, 8'h3C, 3'd4);
    expect_op(0, 8'hCC);
    wait_grants();
    clr_req(0);
    wait_rsps();

    // Opcode sweep, rotating over requesters
    for (int i = 0; i < 8; i++) begin
      set_req(i % NREQ, 8'hA5, 8'h0F, 3'(i));
      expect_op(i % NREQ, sweep_exp[i]);
      wait_grants();
      clr_req(i % NREQ);
    end
    wait_rsps();

    // All requesters valid continuously
    set_req(0, 8'hF0, 8'h0F, 3'd0);
    set_req(1, 8'hF0, 8'h0F, 3'd1);
    set_req(2, 8'h12, 8'h34, 3'd4);
    set_req(3, 8'h55, 8'hFF, 3'd6);
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    repeat (5) expect_op(0, 8'h00);
`else
    expect_op(0, 8'h00);
    expect_op(1, 8'hFF);
    expect_op(2, 8'h26);
    expect_op(3, 8'hAA);
    expect_op(0, 8'h00);
`endif
    wait_grants();
    bus.req_valid = '0;
    wait_rsps();

    // Back-pressure: hold RESP for 10 cycles with another requester waiting
    bus.rsp_ready = 1'b0;
    set_req(2, 8'h3C, 8'hC3, 3'd2);
    expect_op(2, 8'hFF);
    wait_grants();
    clr_req(2);
    set_req(1, 8'h0F, 8'hF0, 3'd3);
    expect_op(1, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 32'd1);
      check("hold_rsp_data", bus.rsp_data, 32'hFF);
      check("hold_rsp_id", bus.rsp_id, 32'd2);
      check("hold_req_ready", bus.req_ready, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_state", dbg_state, RESP);
    @(negedge clk);
    check("hold_done_state", dbg_state, IDLE);
    @(posedge clk);
    wait_grants();
    clr_req(1);
    wait_rsps();

    // Reset during EXEC: operation discarded, pointer restarts at 0
    set_req(1, 8'h77, 8'h11, 3'd0);
    exp_grant_q.push_back(1);
    wait_grants();
    clr_req(1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec_rst_rsp_valid", bus.rsp_valid, 32'd0);
    check("exec_rst_state", dbg_state, IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    set_req(0, 8'hFF, 8'h00, 3'd5);
    set_req(2, 8'hC0, 8'h03, 3'd1);
    expect_op(0, 8'h00);
    wait_grants();
    clr_req(0);
    expect_op(2, 8'hC3);
    wait_grants();
    clr_req(2);
    wait_rsps();

    // Requester 2 withdraws while requester 1 is served
    set_req(1, 8'h81, 8'h18, 3'd1);
    set_req(2, 8'h81, 8'h18, 3'd0);
    expect_op(1, 8'h99);
    wait_grants();
    clr_req(1);
    @(posedge clk);
    #1;
    clr_req(2);
    wait_rsps();
    set_req(3, 8'h81, 8'h18, 3'd3);
    expect_op(3, 8'h66);
    wait_grants();
    clr_req(3);
    wait_rsps();
    set_req(1, 8'hAA, 8'h55, 3'd0);
    set_req(3, 8'hAA, 8'h55, 3'd4);
    expect_op(1, 8'h00);
    wait_grants();
    clr_req(1);
    expect_op(3, 8'hFF);
    wait_grants();
    clr_req(3);
    wait_rsps();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
